// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning HI/LO.
// Results land in HI/LO after a fixed busy window.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAXC =
      (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   hold_hi;
   logic [31:0]   hold_lo;
   logic          hold_wr;

   logic [63:0] a_sx, b_sx, a_zx, b_zx;
   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag, bm_safe, b_safe;
   logic [31:0] mq, mr, sq, sr, uq, ur;
   logic        b_zero;

   // Full-width results for every op, ready to capture at launch
   always_comb begin
      a_sx    = {{32{A[31]}}, A};
      b_sx    = {{32{B[31]}}, B};
      a_zx    = {32'd0, A};
      b_zx    = {32'd0, B};
      prod_s  = a_sx * b_sx;
      prod_u  = a_zx * b_zx;
      b_zero  = (B == 32'd0);
      a_mag   = A[31] ? -A : A;
      b_mag   = B[31] ? -B : B;
      bm_safe = b_zero ? 32'd1 : b_mag;
      b_safe  = b_zero ? 32'd1 : B;
      mq      = a_mag / bm_safe;
      mr      = a_mag % bm_safe;
      sq      = (A[31] ^ B[31]) ? -mq : mq;
      sr      = A[31] ? -mr : mr;
      uq      = A / b_safe;
      ur      = A % b_safe;
   end

   // Launch, count down the busy window, then commit the held result
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         cnt     <= '0;
         HI      <= 32'd0;
         LO      <= 32'd0;
         hold_hi <= 32'd0;
         hold_lo <= 32'd0;
         hold_wr <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (MDop)
                     OP_MULT: begin
                        hold_hi <= prod_s[63:32];
                        hold_lo <= prod_s[31:0];
                        hold_wr <= 1'b1;
                        cnt     <= CW'(MULT_CYCLES);
                        state   <= S_RUN;
                        busy    <= 1'b1;
                     end
                     OP_MULTU: begin
                        hold_hi <= prod_u[63:32];
                        hold_lo <= prod_u[31:0];
                        hold_wr <= 1'b1;
                        cnt     <= CW'(MULT_CYCLES);
                        state   <= S_RUN;
                        busy    <= 1'b1;
                     end
                     OP_DIV: begin
                        hold_hi <= sr;
                        hold_lo <= sq;
                        hold_wr <= !b_zero;
                        cnt     <= CW'(DIV_CYCLES);
                        state   <= S_RUN;
                        busy    <= 1'b1;
                     end
                     OP_DIVU: begin
                        hold_hi <= ur;
                        hold_lo <= uq;
                        hold_wr <= !b_zero;
                        cnt     <= CW'(DIV_CYCLES);
                        state   <= S_RUN;
                        busy    <= 1'b1;
                     end
                     OP_MTHI: HI <= A;
                     OP_MTLO: LO <= A;
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               if (cnt == CW'(1)) begin
                  if (hold_wr) begin
                     HI <= hold_hi;
                     LO <= hold_lo;
                  end
                  hold_wr <= 1'b0;
                  cnt     <= '0;
                  state   <= S_IDLE;
                  busy    <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed table plus hand-written
// sequences for md_unit.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  MDop;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;

   md_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .MDop (MDop),
      .A    (A),
      .B    (B),
      .busy (busy),
      .HI   (HI),
      .LO   (LO)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
      int          ecyc;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
      end
   endtask

   logic [31:0] m_hi, m_lo;

   task automatic run_vec(input vec_t v);
      int n;
      int bad;
      @(negedge clk);
      start = 1'b1;
      MDop  = v.op;
      A     = v.a;
      B     = v.b;
      @(negedge clk);
      start = 1'b0;
      n     = 0;
      bad   = 0;
      while (busy === 1'b1 && n < 200) begin
         if (HI !== m_hi || LO !== m_lo) bad++;
         n++;
         @(negedge clk);
      end
      chk({v.name, "_cycles"}, 32'(n), 32'(v.ecyc));
      chk({v.name, "_hold"}, 32'(bad), 32'd0);
      chk({v.name, "_busy"}, {31'd0, busy}, 32'd0);
      chk({v.name, "_hi"}, HI, v.ehi);
      chk({v.name, "_lo"}, LO, v.elo);
      m_hi = v.ehi;
      m_lo = v.elo;
   endtask

   initial begin
      int n;
      vt[0]  = '{"mult_neg", 3'b000, 32'hFFFFFFFE,
                 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
      vt[1]  = '{"multu_max", 3'b001, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 5};
      vt[2]  = '{"div_neg", 3'b010, 32'hFFFFFFF9,
                 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vt[3]  = '{"mthi_11", 3'b100, 32'h11,
                 32'd0, 32'h11, 32'hFFFFFFFD, 0};
      vt[4]  = '{"mtlo_22", 3'b101, 32'h22,
                 32'd0, 32'h11, 32'h22, 0};
      vt[5]  = '{"divu_z", 3'b011, 32'd7,
                 32'd0, 32'h11, 32'h22, 10};
      vt[6]  = '{"mthi_dead", 3'b100, 32'hDEADBEEF,
                 32'd0, 32'hDEADBEEF, 32'h22, 0};
      vt[7]  = '{"mtlo_1234", 3'b101, 32'h12345678,
                 32'd0, 32'hDEADBEEF, 32'h12345678, 0};
      vt[8]  = '{"div_ovf", 3'b010, 32'h80000000,
                 32'hFFFFFFFF, 32'h0, 32'h80000000, 10};
      vt[9]  = '{"divu_100", 3'b011, 32'd100,
                 32'd7, 32'h2, 32'hE, 10};
      vt[10] = '{"mult_min", 3'b000, 32'h80000000,
                 32'h80000000, 32'h40000000, 32'h0, 5};
      vt[11] = '{"div_negb", 3'b010, 32'd7,
                 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10};
      vt[12] = '{"undef_op", 3'b110, 32'd99,
                 32'd5, 32'h1, 32'hFFFFFFFD, 0};
      vt[13] = '{"div_z", 3'b010, 32'd5,
                 32'd0, 32'h1, 32'hFFFFFFFD, 10};

      reset = 1'b0;
      start = 1'b0;
      MDop  = 3'b000;
      A     = 32'd0;
      B     = 32'd0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      reset = 1'b1;

      foreach (vt[i]) run_vec(vt[i]);

      // mthi then mtlo on consecutive edges
      @(negedge clk);
      start = 1'b1;
      MDop  = 3'b100;
      A     = 32'hCAFE0001;
      @(negedge clk);
      chk("b2b_hi", HI, 32'hCAFE0001);
      chk("b2b_lo_old", LO, 32'hFFFFFFFD);
      MDop  = 3'b101;
      A     = 32'hCAFE0002;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_lo", LO, 32'hCAFE0002);
      chk("b2b_hi2", HI, 32'hCAFE0001);
      chk("b2b_busy", {31'd0, busy}, 32'd0);

      // mthi pulsed while a div is running
      @(negedge clk);
      start = 1'b1;
      MDop  = 3'b010;
      A     = 32'd100;
      B     = 32'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      MDop  = 3'b100;
      A     = 32'd5;
      @(negedge clk);
      start = 1'b0;
      n = 3;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("ign_cycles", 32'(n - 1), 32'd10);
      chk("ign_hi", HI, 32'h2);
      chk("ign_lo", LO, 32'hE);

      // start on the completing edge is ignored
      @(negedge clk);
      start = 1'b1;
      MDop  = 3'b000;
      A     = 32'd3;
      B     = 32'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("edge_busy5", {31'd0, busy}, 32'd1);
      start = 1'b1;
      MDop  = 3'b100;
      A     = 32'h77;
      @(negedge clk);
      start = 1'b0;
      chk("edge_busy", {31'd0, busy}, 32'd0);
      chk("edge_hi", HI, 32'h0);
      chk("edge_lo", LO, 32'hC);
      repeat (2) @(negedge clk);
      chk("edge_hi2", HI, 32'h0);

      // reset in the 3rd busy cycle of a mult
      @(negedge clk);
      start = 1'b1;
      MDop  = 3'b000;
      A     = 32'hFFFFFFFF;
      B     = 32'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mrst_busy3", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_hi", HI, 32'd0);
      chk("mrst_lo", LO, 32'd0);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("mrst_late_hi", HI, 32'd0);
      chk("mrst_late_lo", LO, 32'd0);
      chk("mrst_late_b", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage; owns the HI/LO architectural registers.
- Its HI/LO outputs feed the MEM/WB pipeline copies, which the rs/rt forwarding muxes select for mfhi/mflo.
- Multi-cycle: a busy window tells the hazard unit to stall mult/div/mfhi/mflo/mthi/mtlo behind it.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (min 1).
- DIV_CYCLES, 10, busy cycles for div/divu (min 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse: launch the operation in MDop.
- MDop  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op.
- A  input  32  rs operand.
- B  input  32  rt operand.
- busy  output  1  operation in progress (registered).
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (reset==0 at a posedge): HI=0, LO=0, busy=0, counter=0, state=IDLE. The pending result is discarded. Reset overrides every other input.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- IDLE, start=1, MDop mult/multu/div/divu:
  - Capture the full result into internal hold registers on that edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy is 1 from the next cycle.
- RUN: counter decrements each cycle. On the edge where counter==1, HI/LO take the hold values, busy drops to 0, state returns to IDLE.
- Latency: start asserted in cycle t, so busy=1 for cycles t+1..t+N. New HI/LO are visible from cycle t+N+1, the same cycle busy=0.
- HI/LO hold their old values throughout RUN.
- mult: signed 32x32 to 64; HI=upper 32 bits, LO=lower 32 bits.
- multu: unsigned 32x32 to 64; HI=upper 32 bits, LO=lower 32 bits.
- div (signed):
  - LO=quotient, truncated toward zero.
  - HI=remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B==0, div or divu): still busy for DIV_CYCLES. HI and LO are left unchanged at completion.
- mthi/mtlo with start=1 in IDLE: HI (or LO) = A at that edge. No busy cycle; the other register is unchanged.
- start while busy=1: ignored entirely, including mthi/mtlo. The hazard unit guarantees this does not happen; the block must still be safe if it does.
- start with an undefined MDop: no effect.
- start=1 on the same edge that a RUN completes: busy is still 1 in that cycle, so start is ignored.
- Mid-operation reset: returns to IDLE immediately; the hold result is never written.

Test Plan:
- Reset, then start mult, A=0xFFFFFFFE (-2), B=3 -> busy=1 for 5 cycles. HI=0xFFFFFFFF, LO=0xFFFFFFFA in cycle 6 after start; busy=0 in that cycle.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001. HI/LO hold their old values during busy.
- div, A=0xFFFFFFF9 (-7), B=2 -> 10 busy cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu, A=7, B=0 with prior HI=0x11, LO=0x22 -> busy=1 for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- mthi A=0xDEADBEEF, next cycle mtlo A=0x12345678 -> HI=0xDEADBEEF after 1st edge, LO=0x12345678 after 2nd edge, busy stays 0.
- Two back-to-back cases:
  - start div, then pulse start mthi A=5 during busy -> ignored; HI holds its final div result.
  - start mult, then drop reset low in the 3rd busy cycle -> HI=LO=0, busy=0 on the next edge; no late write afterwards.
